// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV32I words (R, I, LW, SW, BEQ, JAL) from
// decoded control fields and writes them sequentially into imem.
// Optional feature macro: ENC_RANGE_CHECK_EN. When it is defined, immediates
// that do not fit their format (or odd BEQ/JAL offsets) are rejected and
// raise err. When it is undefined, immediates are silently truncated.
module instr_encoder #(
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op_class,
  input  logic [2:0]    funct3,
  input  logic          funct7b5,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [20:0]   imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_err;

  logic [31:0]   w_word;
  logic          w_classOk;
  logic          w_rangeOk;
  logic          w_accept;
  logic [AW:0]   w_countNext;

  // Build the instruction word for the requested class; flag classes 6-7
  always_comb begin
    w_word    = 32'h0000_0000;
    w_classOk = 1'b1;
    case (op_class)
      3'd0: w_word = {(funct7b5 ? 7'h20 : 7'h00), rs2, rs1, funct3, rd, 7'h33};
      3'd1: w_word = {imm[11:0], rs1, funct3, rd, 7'h13};
      3'd2: w_word = {imm[11:0], rs1, 3'b010, rd, 7'h03};
      3'd3: w_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      3'd4: w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'h63};
      3'd5: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
      default: w_classOk = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Immediate fits its format when all bits above the format's sign bit
  // replicate it; branch and jump offsets must also be halfword aligned
  always_comb begin
    w_rangeOk = 1'b1;
    case (op_class)
      3'd1, 3'd2, 3'd3: w_rangeOk = (imm[20:11] == 10'h000) || (imm[20:11] == 10'h3FF);
      3'd4:             w_rangeOk = ((imm[20:12] == 9'h000) || (imm[20:12] == 9'h1FF)) && !imm[0];
      3'd5:             w_rangeOk = !imm[0];
      default:          w_rangeOk = 1'b1;
    endcase
  end
`else
  logic w_unusedImm0;
  assign w_unusedImm0 = imm[0];
  assign w_rangeOk    = 1'b1;
`endif

  assign in_ready    = (r_state == ST_IDLE) && !r_full;
  assign w_accept    = in_valid && in_ready;
  assign w_countNext = r_count + LP_ONE;

  // Sequencer: accept in IDLE, strobe for one cycle in WRITE, then advance
  // the pointer; clr outranks all traffic and returns to an empty buffer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_classOk && w_rangeOk) begin
              r_we    <= 1'b1;
              r_wdata <= w_word;
              r_state <= ST_WRITE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_we    <= 1'b0;
          r_count <= w_countNext;
          if (w_countNext == LP_DEPTH) begin
            r_full  <= 1'b1;
            r_state <= ST_FULL;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_FULL: begin
          r_we <= 1'b0;
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // A clr or reset arriving during WRITE cancels that cycle's strobe
  assign imem_we    = r_we && reset_n && !clr;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign full       = r_full;
  assign err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed literal cases plus randomized requests checked
// every cycle against a transaction-level model of the loader.
module tb_instr_encoder;

  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op_class;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [20:0]   imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  int          testCount;
  int          failCount;
  int          strobeCount;
  logic [31:0] lastWord;
  logic [31:0] lastAddr;
  bit          checkEn;

  // Model state: a word waiting to be strobed, words written, sticky error
  bit          mPending;
  logic [31:0] mPendWord;
  int          mPendAddr;
  int          mWords;
  bit          mErr;

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .funct7b5(funct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int immToInt(logic [20:0] v);
    return v[20] ? (int'(v) - (1 << 21)) : int'(v);
  endfunction

  function automatic bit refLegal(int cls, int immv);
    if (cls > 5) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    if (cls >= 1 && cls <= 3) return (immv >= -2048) && (immv <= 2047);
    if (cls == 4) return (immv >= -4096) && (immv <= 4094) && (immv % 2 == 0);
    if (cls == 5) return (immv % 2 == 0);
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] refEncode(int cls, int f3, int f7, int rdv, int rs1v, int rs2v, int immv);
    logic [31:0] u;
    logic [31:0] w;
    u = 32'(immv);
    w = 32'h0;
    case (cls)
      0: w = (f7 != 0 ? 32'h4000_0000 : 32'h0) | (32'(rs2v) << 20) | (32'(rs1v) << 15)
             | (32'(f3) << 12) | (32'(rdv) << 7) | 32'h33;
      1: w = ((u & 32'hFFF) << 20) | (32'(rs1v) << 15) | (32'(f3) << 12) | (32'(rdv) << 7) | 32'h13;
      2: w = ((u & 32'hFFF) << 20) | (32'(rs1v) << 15) | (32'd2 << 12) | (32'(rdv) << 7) | 32'h03;
      3: w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2v) << 20) | (32'(rs1v) << 15) | (32'd2 << 12)
             | ((u & 32'h1F) << 7) | 32'h23;
      4: w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2v) << 20)
             | (32'(rs1v) << 15) | (32'(f3) << 12) | (((u >> 1) & 32'hF) << 8)
             | (((u >> 11) & 32'h1) << 7) | 32'h63;
      5: w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 32'h1) << 20)
             | (((u >> 12) & 32'hFF) << 12) | (32'(rdv) << 7) | 32'h6F;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on every clock edge from the inputs it sees there
  always @(posedge clk) begin
    bit acc;
    if (!reset_n || clr) begin
      mPending = 1'b0;
      mWords   = 0;
      mErr     = 1'b0;
    end else begin
      acc = in_valid && !mPending && (mWords != DEPTH);
      if (mPending) begin
        mPending = 1'b0;
        mWords++;
      end else if (acc) begin
        if (refLegal(int'(op_class), immToInt(imm))) begin
          mPending  = 1'b1;
          mPendWord = refEncode(int'(op_class), int'(funct3), int'(funct7b5), int'(rd),
                                int'(rs1), int'(rs2), immToInt(imm));
          mPendAddr = mWords;
        end else begin
          mErr = 1'b1;
        end
      end
    end
  end

  // Compare all DUT outputs against the model on the falling edge
  always @(negedge clk) begin
    logic expWe;
    if (checkEn) begin
      expWe = mPending && reset_n && !clr;
      checkOutput("imem_we", 32'(imem_we), 32'(expWe));
      if (expWe) begin
        checkOutput("imem_addr", 32'(imem_addr), 32'(mPendAddr));
        checkOutput("imem_wdata", imem_wdata, mPendWord);
      end
      checkOutput("count", 32'(count), 32'(mWords));
      checkOutput("full", 32'(full), 32'(mWords == DEPTH));
      checkOutput("err", 32'(err), 32'(mErr));
      checkOutput("in_ready", 32'(in_ready), 32'(!mPending && (mWords != DEPTH)));
    end
    if (imem_we === 1'b1) begin
      strobeCount++;
      lastWord = imem_wdata;
      lastAddr = 32'(imem_addr);
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input int cls, input int f3, input int f7, input int rdv, input int rs1v,
                               input int rs2v, input int immv, input int budget, output bit accepted);
    bit rdy;
    op_class = 3'(cls);
    funct3   = 3'(f3);
    funct7b5 = 1'(f7);
    rd       = 5'(rdv);
    rs1      = 5'(rs1v);
    rs2      = 5'(rs2v);
    imm      = 21'(immv);
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < budget && !accepted; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #2;
      if (rdy) accepted = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    idleCycles(1);
    clr = 1'b0;
  endtask

  // Watchdog so a stuck run still terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int s0;
    int cls;
    int immv;
    int pick;
    testCount   = 0;
    failCount   = 0;
    strobeCount = 0;
    lastWord    = 32'h0;
    lastAddr    = 32'h0;
    checkEn     = 1'b0;
    mPending    = 1'b0;
    mWords      = 0;
    mErr        = 1'b0;
    mPendWord   = 32'h0;
    mPendAddr   = 0;
    reset_n  = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    op_class = 3'd0;
    funct3   = 3'd0;
    funct7b5 = 1'b0;
    rd       = 5'd0;
    rs1      = 5'd0;
    rs2      = 5'd0;
    imm      = 21'd0;

    idleCycles(2);
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_we", 32'(imem_we), 32'h0);
    checkOutput("rst_addr", 32'(imem_addr), 32'h0);
    checkOutput("rst_wdata", imem_wdata, 32'h0);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_full", 32'(full), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    idleCycles(1);

    applyStimulus(0, 0, 0, 3, 1, 2, 0, 4, acc);
    checkOutput("acc_add", 32'(acc), 32'h1);
    idleCycles(2);
    checkOutput("lit_add_word", lastWord, 32'h002081B3);
    checkOutput("lit_add_addr", lastAddr, 32'h0);
    checkOutput("lit_add_count", 32'(count), 32'h1);

    applyStimulus(2, 0, 0, 5, 0, 0, 8, 4, acc);
    idleCycles(2);
    checkOutput("lit_lw_word", lastWord, 32'h00802283);
    checkOutput("lit_lw_addr", lastAddr, 32'h1);

    applyStimulus(3, 0, 0, 0, 1, 2, 4, 4, acc);
    idleCycles(2);
    checkOutput("lit_sw_word", lastWord, 32'h0020A223);

    applyStimulus(4, 0, 0, 0, 0, 0, -4, 4, acc);
    idleCycles(2);
    checkOutput("lit_beq_word", lastWord, 32'hFE000EE3);
    checkOutput("lit_beq_addr", lastAddr, 32'h3);
    checkOutput("lit_full", 32'(full), 32'h1);
    checkOutput("lit_full_ready", 32'(in_ready), 32'h0);

    applyStimulus(0, 0, 1, 4, 4, 4, 0, 6, acc);
    checkOutput("lit_held5", 32'(acc), 32'h0);
    checkOutput("lit_held5_count", 32'(count), 32'h4);

    pulseClr();
    checkOutput("lit_clr_count", 32'(count), 32'h0);
    checkOutput("lit_clr_ready", 32'(in_ready), 32'h1);

    s0 = strobeCount;
    applyStimulus(7, 0, 0, 1, 1, 1, 0, 4, acc);
    idleCycles(2);
    checkOutput("lit_bad_err", 32'(err), 32'h1);
    checkOutput("lit_bad_nowe", 32'(strobeCount), 32'(s0));
    checkOutput("lit_bad_count", 32'(count), 32'h0);
    pulseClr();
    checkOutput("lit_clr_err", 32'(err), 32'h0);

    s0 = strobeCount;
    applyStimulus(0, 0, 0, 1, 2, 3, 0, 4, acc);
    pulseClr();
    idleCycles(2);
    checkOutput("lit_clrwr_nowe", 32'(strobeCount), 32'(s0));
    checkOutput("lit_clrwr_count", 32'(count), 32'h0);

    s0 = strobeCount;
    applyStimulus(0, 0, 0, 1, 2, 3, 0, 4, acc);
    reset_n = 1'b0;
    idleCycles(1);
    reset_n = 1'b1;
    idleCycles(2);
    checkOutput("lit_rstwr_nowe", 32'(strobeCount), 32'(s0));
    checkOutput("lit_rstwr_count", 32'(count), 32'h0);

    s0 = strobeCount;
    applyStimulus(1, 0, 0, 0, 0, 0, 4096, 4, acc);
    idleCycles(2);
`ifdef ENC_RANGE_CHECK_EN
    checkOutput("lit_i4096_err", 32'(err), 32'h1);
    checkOutput("lit_i4096_nowe", 32'(strobeCount), 32'(s0));
    pulseClr();
`else
    checkOutput("lit_i4096_word", lastWord, 32'h00000013);
    checkOutput("lit_i4096_count", 32'(count), 32'h1);
`endif

    applyStimulus(5, 0, 0, 1, 0, 0, 8, 4, acc);
    idleCycles(2);
    checkOutput("lit_jal_word", lastWord, 32'h008000EF);

    pulseClr();
    for (int n = 0; n < 400; n++) begin
      if (full) pulseClr();
      cls  = int'($urandom_range(0, 7));
      pick = int'($urandom_range(0, 9));
      case (pick)
        0: immv = 2047;
        1: immv = 2048;
        2: immv = -2048;
        3: immv = -2049;
        4: immv = 4094;
        5: immv = -4096;
        6: immv = 4095 - 2 * int'($urandom_range(0, 1));
        default: immv = immToInt(21'($urandom));
      endcase
      applyStimulus(cls, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), immv, 4, acc);
      if ($urandom_range(0, 19) == 0) pulseClr();
      else if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        idleCycles(1);
        reset_n = 1'b1;
      end
      idleCycles(int'($urandom_range(0, 2)));
    end

    idleCycles(3);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
